psum_collector: RTL and testbench

Receives partial-sum output rows from the systolic array (`psumout_en` / `psumout_row_sel_in` / `psumout_data`) and writes each completed N-row result tile to the scratchpad store path. It is the consuming end of the array's output interface, sitting between `systolic_array` and the scratchpad store engine inside `memory_subsystem`. A two-bank ping-pong buffer lets the array keep emitting rows for tile k+1 while tile k is being drained. Backpressure goes to the array through `collector_ready`.

---
 rtl/sp_types_pkg.sv | 15 +
 rtl/psum_bank.sv | 56 +++++
 rtl/psum_collector.sv | 129 ++++++++++++
 tb/tb_psum_collector.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_types_pkg.sv
// rtl/sp_types_pkg.sv - shared scratchpad types for the psum collector path
package sp_types_pkg;

    localparam int PSUM_N  = 4;
    localparam int PSUM_DW = 16;

    typedef logic [PSUM_N*PSUM_DW-1:0]  psum_row_t;
    typedef logic [$clog2(PSUM_N)-1:0] psum_rowsel_t;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/psum_bank.sv
// rtl/psum_bank.sv - one ping-pong bank: N rows, row_valid map, base register, full flag
module psum_bank #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 wr_en,
    input  logic [$clog2(N)-1:0] wr_sel,
    input  logic [N*DW-1:0]      wr_row,
    input  logic [AW-1:0]        base_in,
    input  logic                 clr,
    input  logic [$clog2(N)-1:0] rd_sel,
    output logic [N*DW-1:0]      rd_row,
    output logic [N-1:0]         row_valid,
    output logic [AW-1:0]        base,
    output logic                 full,
    output logic                 completing
);

    logic [N*DW-1:0] rows [N];
    logic [N-1:0]    sel_hot;

    assign sel_hot    = N'(1) << wr_sel;
    assign completing = wr_en && ((row_valid | sel_hot) == {N{1'b1}});
    assign rd_row     = rows[rd_sel];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            row_valid <= '0;
            base      <= '0;
            full      <= 1'b0;
        end else if (clr) begin
            row_valid <= '0;
            full      <= 1'b0;
        end else if (wr_en) begin
            row_valid <= row_valid | sel_hot;
            // The first row of a tile carries the store base for the whole tile.
            if (row_valid == '0) begin
                base <= base_in;
            end
            if (completing) begin
                full <= 1'b1;
            end
        end
    end

    // Payload needs no reset: row_valid decides what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rows[wr_sel] <= wr_row;
        end
    end

endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - collects systolic array output rows into ping-pong tiles and drains them to the store path
module psum_collector
    import sp_types_pkg::*;
#(
    parameter int N          = 4,
    parameter int DW         = 16,
    parameter int AW         = 32,
    parameter int ROW_STRIDE = 16
) (
    input  logic                 CLK,
    input  logic                 nrst,
    input  logic                 psumout_en,
    input  logic [$clog2(N)-1:0] psumout_row_sel_in,
    input  logic [N*DW-1:0]      psumout_data,
    input  logic [AW-1:0]        tile_base,
    output logic                 collector_ready,
    output logic                 wr_req,
    input  logic                 wr_ready,
    output logic [AW-1:0]        wr_addr,
    output logic [N*DW-1:0]      wr_data,
    output logic                 tile_done,
    output logic                 err_overflow,
    output logic                 err_dup_row
);

    localparam int SW = $clog2(N);

    drain_state_t    state, state_next;
    logic [SW-1:0]   row_cnt, row_cnt_next;
    logic            fill_bank, drain_bank;
    logic            drain_clr, tile_done_next;
    logic            accept, dup, row_we;
    logic [1:0]      bank_full, bank_we, bank_clr, bank_completing;
    logic [N-1:0]    bank_valid [2];
    logic [AW-1:0]   bank_base  [2];
    logic [N*DW-1:0] bank_rd    [2];

    assign collector_ready = !bank_full[fill_bank];
    assign accept          = psumout_en && collector_ready;
    assign dup             = bank_valid[fill_bank][psumout_row_sel_in];
    assign row_we          = accept && !dup;
    assign bank_we         = row_we    ? (fill_bank  ? 2'b10 : 2'b01) : 2'b00;
    assign bank_clr        = drain_clr ? (drain_bank ? 2'b10 : 2'b01) : 2'b00;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        psum_bank #(
            .N  (N),
            .DW (DW),
            .AW (AW)
        ) u_bank (
            .clk        (CLK),
            .nrst       (nrst),
            .wr_en      (bank_we[b]),
            .wr_sel     (psumout_row_sel_in),
            .wr_row     (psumout_data),
            .base_in    (tile_base),
            .clr        (bank_clr[b]),
            .rd_sel     (row_cnt),
            .rd_row     (bank_rd[b]),
            .row_valid  (bank_valid[b]),
            .base       (bank_base[b]),
            .full       (bank_full[b]),
            .completing (bank_completing[b])
        );
    end

    // Request fields come only from registered state, so they hold through a stall.
    always_comb begin
        state_next     = state;
        row_cnt_next   = row_cnt;
        drain_clr      = 1'b0;
        tile_done_next = 1'b0;
        wr_req         = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        case (state)
            D_IDLE: begin
                if (bank_full[drain_bank]) begin
                    row_cnt_next = '0;
                    state_next   = D_REQ;
                end
            end
            D_REQ: begin
                wr_req  = 1'b1;
                wr_addr = bank_base[drain_bank] + AW'(row_cnt) * AW'(ROW_STRIDE);
                wr_data = bank_rd[drain_bank];
                if (wr_ready) begin
                    if (row_cnt == SW'(N - 1)) begin
                        drain_clr      = 1'b1;
                        tile_done_next = 1'b1;
                        state_next     = D_IDLE;
                    end else begin
                        row_cnt_next = row_cnt + 1'b1;
                    end
                end
            end
            default: state_next = D_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state        <= D_IDLE;
            row_cnt      <= '0;
            fill_bank    <= 1'b0;
            drain_bank   <= 1'b0;
            tile_done    <= 1'b0;
            err_overflow <= 1'b0;
            err_dup_row  <= 1'b0;
        end else begin
            state     <= state_next;
            row_cnt   <= row_cnt_next;
            tile_done <= tile_done_next;
            if (drain_clr) begin
                drain_bank <= ~drain_bank;
            end
            if (|bank_completing) begin
                fill_bank <= ~fill_bank;
            end
            if (psumout_en && !collector_ready) begin
                err_overflow <= 1'b1;
            end
            if (accept && dup) begin
                err_dup_row <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - self-checking bench for psum_collector
module tb_psum_collector;

    localparam int N      = 4;
    localparam int DW     = 16;
    localparam int AW     = 32;
    localparam int STRIDE = 16;
    localparam int RW     = N * DW;

    logic          CLK = 1'b0;
    logic          nrst;
    logic          psumout_en;
    logic [1:0]    psumout_row_sel_in;
    logic [RW-1:0] psumout_data;
    logic [AW-1:0] tile_base;
    logic          collector_ready;
    logic          wr_req;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_data;
    logic          tile_done;
    logic          err_overflow;
    logic          err_dup_row;

    always #5 CLK = ~CLK;

    psum_collector #(
        .N          (N),
        .DW         (DW),
        .AW         (AW),
        .ROW_STRIDE (STRIDE)
    ) dut (
        .CLK                (CLK),
        .nrst               (nrst),
        .psumout_en         (psumout_en),
        .psumout_row_sel_in (psumout_row_sel_in),
        .psumout_data       (psumout_data),
        .tile_base          (tile_base),
        .collector_ready    (collector_ready),
        .wr_req             (wr_req),
        .wr_ready           (wr_ready),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .tile_done          (tile_done),
        .err_overflow       (err_overflow),
        .err_dup_row        (err_dup_row)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rowpat(int r);
        logic [15:0] h;
        h = 16'(16'h1111 * (r + 1));
        return {h, h, h, h};
    endfunction

    // wr_ready driver: 0 = fixed level, 1 = 1,0,0,1 pattern, 2 = random
    int   ready_mode  = 0;
    logic ready_fixed = 1'b1;
    int   pat_idx     = 0;
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge CLK); #1;
            case (ready_mode)
                0: wr_ready = ready_fixed;
                1: begin
                    wr_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                    pat_idx++;
                end
                default: wr_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Reference model: tiles assembled from accepted rows, writes expected in row order
    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            exp_tiles = 0;
    int            done_cnt  = 0;
    logic [RW-1:0] m_rows [N];
    logic [N-1:0]  m_valid = '0;
    logic [AW-1:0] m_base  = '0;
    bit            m_dup   = 0;
    bit            m_ovf   = 0;
    bit            sb_on   = 0;

    task automatic model_accept(int sel, logic [RW-1:0] d, logic [AW-1:0] base);
        if (m_valid[sel]) begin
            m_dup = 1;
        end else begin
            if (m_valid == '0) m_base = base;
            m_rows[sel]  = d;
            m_valid[sel] = 1'b1;
            if (&m_valid) begin
                for (int i = 0; i < N; i++)
                    exp_q.push_back(wr_t'{addr: m_base + AW'(i * STRIDE), data: m_rows[i]});
                exp_tiles++;
                m_valid = '0;
            end
        end
    endtask

    task automatic present(int sel, logic [RW-1:0] d, logic [AW-1:0] base, bit expect_accept);
        chk($sformatf("ready_at_row%0d", sel), collector_ready, expect_accept);
        psumout_en         = 1'b1;
        psumout_row_sel_in = 2'(sel);
        psumout_data       = d;
        tile_base          = base;
        if (expect_accept) model_accept(sel, d, base);
        else m_ovf = 1;
        @(posedge CLK); #1;
        psumout_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!collector_ready && n < 300) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || done_cnt != exp_tiles) && n < 1000) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({name, "_writes_left"}, exp_q.size(), 0);
        chk({name, "_tile_done_count"}, done_cnt, exp_tiles);
    endtask

    task automatic chk_reset_outputs(string name);
        chk({name, "_ready"},    collector_ready, 1);
        chk({name, "_wr_req"},   wr_req, 0);
        chk({name, "_wr_addr"},  wr_addr, 0);
        chk({name, "_wr_data"},  wr_data, 0);
        chk({name, "_done"},     tile_done, 0);
        chk({name, "_err_ovf"},  err_overflow, 0);
        chk({name, "_err_dup"},  err_dup_row, 0);
    endtask

    // Monitor: write ordering/content, stall stability, tile_done pulses
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [RW-1:0] prev_data;
    always @(negedge CLK) begin
        if (nrst && sb_on) begin
            if (prev_stall) begin
                chk("stall_wr_req",  wr_req,  1);
                chk("stall_wr_addr", wr_addr, prev_addr);
                chk("stall_wr_data", wr_data, prev_data);
            end
            if (wr_req && wr_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h with nothing pending", wr_addr, wr_data);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("write_addr", wr_addr, w.addr);
                    chk("write_data", wr_data, w.data);
                end
            end
            if (tile_done) done_cnt++;
            prev_stall = wr_req && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    typedef struct {
        bit            en;
        int            sel;
        logic [RW-1:0] data;
        logic [AW-1:0] base;
        bit            e_ready;
        bit            e_req;
        logic [AW-1:0] e_addr;
        logic [RW-1:0] e_data;
        bit            e_done;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t          vecs[10];
        int            ord2[4];
        int            order[4];
        logic [RW-1:0] d;
        logic [AW-1:0] b;

        nrst               = 1'b0;
        psumout_en         = 1'b0;
        psumout_row_sel_in = '0;
        psumout_data       = '0;
        tile_base          = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_outputs("reset");
        nrst = 1'b1;

        // Cycle-exact single tile, rows 0..3, base 0x100, wr_ready high
        for (int k = 0; k < 4; k++)
            vecs[k] = '{1, k, rowpat(k), (k == 0) ? 32'h100 : 32'hDEAD0, 1, 0, 32'h0, '0, 0};
        for (int k = 0; k < 4; k++)
            vecs[4 + k] = '{0, 0, '0, 32'h0, 1, 1, 32'h100 + 32'(k * STRIDE), rowpat(k), 0};
        vecs[8] = '{0, 0, '0, 32'h0, 1, 0, 32'h0, '0, 1};
        vecs[9] = '{0, 0, '0, 32'h0, 1, 0, 32'h0, '0, 0};
        for (int k = 0; k < 10; k++) begin
            psumout_en         = vecs[k].en;
            psumout_row_sel_in = 2'(vecs[k].sel);
            psumout_data       = vecs[k].data;
            tile_base          = vecs[k].base;
            @(posedge CLK); #1;
            chk($sformatf("vec%0d_ready", k),   collector_ready, vecs[k].e_ready);
            chk($sformatf("vec%0d_wr_req", k),  wr_req,          vecs[k].e_req);
            chk($sformatf("vec%0d_wr_addr", k), wr_addr,         vecs[k].e_addr);
            chk($sformatf("vec%0d_wr_data", k), wr_data,         vecs[k].e_data);
            chk($sformatf("vec%0d_done", k),    tile_done,       vecs[k].e_done);
        end
        psumout_en = 1'b0;
        sb_on      = 1;

        // Out-of-order arrival still drains 0..N-1
        ord2 = '{3, 1, 0, 2};
        for (int k = 0; k < 4; k++)
            present(ord2[k], {$urandom, $urandom}, 32'h2000, 1);
        wait_drain("ooo");

        // Two tiles fill while stalled, then a dropped overflow row
        ready_fixed = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 4; r++)
                present(r, {$urandom, $urandom}, 32'h3000 + 32'(t * 'h100), 1);
        chk("ovf_ready_low", collector_ready, 0);
        present(0, {$urandom, $urandom}, 32'h9999, 0);
        chk("ovf_ready_still_low", collector_ready, 0);
        chk("err_overflow", err_overflow, m_ovf);
        ready_fixed = 1'b1;
        wait_drain("overflow");

        // Duplicate row within a tile keeps the first data
        present(0, {$urandom, $urandom}, 32'h4000, 1);
        present(1, 64'hAAAA_AAAA_AAAA_AAAA, 32'h4000, 1);
        present(1, 64'hBBBB_BBBB_BBBB_BBBB, 32'h4000, 1);
        chk("err_dup_row", err_dup_row, m_dup);
        present(2, {$urandom, $urandom}, 32'h4000, 1);
        present(3, {$urandom, $urandom}, 32'h4000, 1);
        wait_drain("dup");

        // wr_ready toggling 1,0,0,1 during a drain
        ready_mode = 1;
        for (int r = 0; r < 4; r++)
            present(r, {$urandom, $urandom}, 32'h4800, 1);
        wait_drain("toggle");
        ready_mode = 0;
        repeat (2) begin @(posedge CLK); #1; end

        // Reset after two rows discards the partial tile
        present(0, {$urandom, $urandom}, 32'h5000, 1);
        present(1, {$urandom, $urandom}, 32'h5000, 1);
        nrst = 1'b0;
        @(posedge CLK); #1;
        chk_reset_outputs("midtile_reset");
        m_valid = '0;
        m_dup   = 0;
        m_ovf   = 0;
        nrst    = 1'b1;
        for (int r = 0; r < 4; r++)
            present(r, {$urandom, $urandom}, 32'h6000, 1);
        wait_drain("post_reset");

        // Random tiles, random order, random gaps, occasional duplicates, random wr_ready
        ready_mode = 2;
        for (int t = 0; t < 20; t++) begin
            order = '{0, 1, 2, 3};
            for (int i = 3; i > 0; i--) begin
                int j;
                int tmp;
                j        = $urandom_range(0, i);
                tmp      = order[i];
                order[i] = order[j];
                order[j] = tmp;
            end
            b = (t == 0) ? 32'hFFFF_FFE8 : {$urandom_range(0, 32'hFFFF), 4'h0, 12'h0};
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
                d = {$urandom, $urandom};
                wait_ready();
                present(order[k], d, b, 1);
                if (k < 3 && $urandom_range(0, 7) == 0) begin
                    wait_ready();
                    present(order[k], ~d, b, 1);
                end
            end
        end
        wait_drain("random");
        chk("random_err_dup", err_dup_row, m_dup);
        chk("random_err_ovf", err_overflow, m_ovf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
